// File: rtl/nand_seq_pkg.sv
// rtl/nand_seq_pkg.sv - shared types and constants for the NAND chain self-test sequencer
package nand_seq_pkg;

  localparam int VEC_W        = 3;
  localparam int ERR_W        = 4;
  localparam int SETTLE_CNT_W = 4;
  localparam logic [VEC_W-1:0] VEC_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Golden response of the two-stage chain: {d, e} with d = ~(a&b), e = ~(c&d).
  function automatic logic [1:0] nand_chain_expect(input logic [VEC_W-1:0] v);
    logic d;
    d = ~(v[2] & v[1]);
    return {d, ~(v[0] & d)};
  endfunction

endpackage

// File: rtl/nand_seq_settle_timer.sv
// rtl/nand_seq_settle_timer.sv - loadable down-counter that times the settle interval per vector
module nand_seq_settle_timer
  import nand_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  // A 4-bit counter holds at most 15, so the settle interval must stay within 1..15.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  logic [SETTLE_CNT_W-1:0] cnt_q;
  logic [SETTLE_CNT_W-1:0] cnt_d;

  // Load takes priority; otherwise count down while enabled and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/nand_chain_seq_ctrl.sv
// rtl/nand_chain_seq_ctrl.sv - exhaustive self-test sequencer for the NAND chain (optional NAND_SEQ_FAIL_CAPTURE_EN)
module nand_chain_seq_ctrl
  import nand_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] vec,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  input  logic             dut_d,
  input  logic             dut_e
`ifdef NAND_SEQ_FAIL_CAPTURE_EN
  ,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic [1:0]       first_fail_de,
  output logic             fail_valid
`endif
);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       drv_q, drv_d;

  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_zero;
  logic             start_acc;
  logic             mismatch;

  nand_seq_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (tmr_en),
    .zero (tmr_zero)
  );

  assign start_acc = (state_q == IDLE) && start;
  assign mismatch  = ({dut_d, dut_e} != nand_chain_expect(vec_q));

  // Next-state logic; outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          vec_d    = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end
      DRIVE: begin
        if (tmr_zero) begin
          state_d = CHECK;
        end else begin
          tmr_en = 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + ERR_W'(1);
        end
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = DRIVE;
          vec_d    = vec_q + 1'b1;
          tmr_load = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == DRIVE) || (state_d == CHECK);
    done_d = (state_d == DONE);
    drv_d  = busy_d ? vec_d : 3'b000;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drv_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drv_q   <= drv_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec     = vec_q;
  assign dut_a   = drv_q[2];
  assign dut_b   = drv_q[1];
  assign dut_c   = drv_q[0];

`ifdef NAND_SEQ_FAIL_CAPTURE_EN
  logic [VEC_W-1:0] ff_vec_q, ff_vec_d;
  logic [1:0]       ff_de_q, ff_de_d;
  logic             ff_valid_q, ff_valid_d;

  // Latch the first mismatching vector of a run; cleared when a new run is accepted.
  always_comb begin
    ff_vec_d   = ff_vec_q;
    ff_de_d    = ff_de_q;
    ff_valid_d = ff_valid_q;
    if (start_acc) begin
      ff_vec_d   = '0;
      ff_de_d    = '0;
      ff_valid_d = 1'b0;
    end else if ((state_q == CHECK) && mismatch && !ff_valid_q) begin
      ff_vec_d   = vec_q;
      ff_de_d    = {dut_d, dut_e};
      ff_valid_d = 1'b1;
    end
  end

  // First-failure capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vec_q   <= '0;
      ff_de_q    <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      ff_vec_q   <= ff_vec_d;
      ff_de_q    <= ff_de_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  assign first_fail_vec = ff_vec_q;
  assign first_fail_de  = ff_de_q;
  assign fail_valid     = ff_valid_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_nand_chain_seq_ctrl.sv
// tb/tb_nand_chain_seq_ctrl.sv - self-checking bench for nand_chain_seq_ctrl with a behavioural NAND chain
module tb_nand_chain_seq_ctrl;

  localparam int S        = 2;
  localparam int BUSY_END = 8 * (S + 1);
  localparam int DONE_CYC = 8 * (S + 1) + 1;

  typedef struct {
    int         done_cyc;
    bit         pass;
    logic [3:0] err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [2:0] vec;
  logic       dut_a, dut_b, dut_c;
  logic       dut_d, dut_e;
`ifdef NAND_SEQ_FAIL_CAPTURE_EN
  logic [2:0] first_fail_vec;
  logic [1:0] first_fail_de;
  logic       fail_valid;
`endif

  int   fault_mode;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  logic chain_d, chain_e;
  always_comb begin
    chain_d = ~(dut_a & dut_b);
    chain_e = ~(dut_c & chain_d);
    dut_d   = chain_d;
    dut_e   = chain_e;
    if (fault_mode == 1) begin
      dut_e = 1'b1;
    end else if (fault_mode == 2) begin
      dut_d = 1'b0;
      dut_e = ~(dut_c & 1'b0);
    end
  end

  nand_chain_seq_ctrl #(.SETTLE_CYCLES(S)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .vec     (vec),
    .dut_a   (dut_a),
    .dut_b   (dut_b),
    .dut_c   (dut_c),
    .dut_d   (dut_d),
    .dut_e   (dut_e)
`ifdef NAND_SEQ_FAIL_CAPTURE_EN
    ,
    .first_fail_vec (first_fail_vec),
    .first_fail_de  (first_fail_de),
    .fail_valid     (fail_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_cnt), 32'd0);
    check({tag, "_vec"}, 32'(vec), 32'd0);
    check({tag, "_pins"}, 32'({dut_a, dut_b, dut_c}), 32'd0);
  endtask

  task automatic pop_and_compare(input int cyc);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_done", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      check("pass", 32'(pass), 32'(e.pass));
      check("err_cnt", 32'(err_cnt), 32'(e.err));
      check("vec_final", 32'(vec), 32'd7);
    end
  endtask

  // One run started from IDLE; cycle 0 is the cycle whose ending edge samples start.
  task automatic run_once(input int mode, input int exp_err, input bit repulse);
    exp_t e;
    int   cyc;
    bit   seen;
    int   k;
    fault_mode = mode;
    e.done_cyc = DONE_CYC;
    e.pass     = (exp_err == 0);
    e.err      = 4'(exp_err);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      k = (cyc - 1) / (S + 1);
      check("busy", 32'(busy), 32'((cyc >= 1) && (cyc <= BUSY_END)));
      check("done", 32'(done), 32'(cyc == DONE_CYC));
      if (cyc <= BUSY_END) begin
        check("vec", 32'(vec), 32'(k));
        check("pins", 32'({dut_a, dut_b, dut_c}), 32'(k));
      end
      if (done) begin
        check("pins_done", 32'({dut_a, dut_b, dut_c}), 32'd0);
        pop_and_compare(cyc);
        seen = 1'b1;
      end
      if (repulse && cyc == 10) start = 1'b1;
      if (repulse && cyc == 11) start = 1'b0;
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("held_pass", 32'(pass), 32'(exp_err == 0));
    check("held_err", 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    int   cyc;
    int   ndone;
    exp_t e;
    vectors     = 0;
    miscompares = 0;
    fault_mode  = 0;
    rst         = 1'b0;
    start       = 1'b0;

    #2 rst = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    run_once(0, 0, 1'b0);
`ifdef NAND_SEQ_FAIL_CAPTURE_EN
    check("ff_valid_clean", 32'(fail_valid), 32'd0);
`endif

    run_once(1, 3, 1'b0);
`ifdef NAND_SEQ_FAIL_CAPTURE_EN
    check("ff_valid_e1", 32'(fail_valid), 32'd1);
    check("ff_vec_e1", 32'(first_fail_vec), 32'd1);
    check("ff_de_e1", 32'(first_fail_de), 32'b11);
`endif

    run_once(2, 6, 1'b0);
`ifdef NAND_SEQ_FAIL_CAPTURE_EN
    check("ff_vec_d0", 32'(first_fail_vec), 32'd0);
    check("ff_de_d0", 32'(first_fail_de), 32'b01);
`endif

    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 4 * (S + 1) + 1) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_vec", 32'(vec), 32'd4);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
`ifdef NAND_SEQ_FAIL_CAPTURE_EN
    check("mid_ff_valid", 32'(fail_valid), 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("after_rst_idle", 32'(busy | done), 32'd0);
    end

    run_once(0, 0, 1'b0);
    run_once(0, 0, 1'b1);

    fault_mode = 0;
    e.pass = 1'b1;
    e.err  = 4'd0;
    e.done_cyc = DONE_CYC;
    sb_q.push_back(e);
    e.done_cyc = 2 * DONE_CYC + 1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    cyc   = 0;
    ndone = 0;
    while (ndone < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        pop_and_compare(cyc);
        ndone++;
        if (ndone == 2) start = 1'b0;
      end
    end
    if (ndone < 2) begin
      check("held_start_timeout", 32'(ndone), 32'd2);
      start = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    check("held_start_stop", 32'(busy), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
